// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: handshake, flag, LUT-write and jump-control bundle between the sequencer and branch_ctrl
interface branch_ctrl_if #(parameter int D = 12) ();
   logic          start;
   logic [D-1:0]  prog_ctr;
   logic [8:0]    instr;
   logic          alu_z;
   logic          alu_c;
   logic          alu_n;
   logic          flag_we;
   logic          lut_we;
   logic [2:0]    lut_addr;
   logic [D-1:0]  lut_data;
   logic          BranchFlag;
   logic          BranchInvert;
   logic          reljump;
   logic          absjump;
   logic [D-1:0]  target;
   logic          done;
   logic [15:0]   taken_cnt;
   modport master (
      output start, prog_ctr, instr, alu_z, alu_c, alu_n, flag_we, lut_we, lut_addr, lut_data,
      input  BranchFlag, BranchInvert, reljump, absjump, target, done, taken_cnt
   );
   modport slave (
      input  start, prog_ctr, instr, alu_z, alu_c, alu_n, flag_we, lut_we, lut_addr, lut_data,
      output BranchFlag, BranchInvert, reljump, absjump, target, done, taken_cnt
   );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: decodes branch instructions against registered flags and drives PC jump controls
module branch_ctrl #(parameter int D = 12) (
   input logic        clk,
   input logic        reset,
   branch_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t         state_q, state_d;
   logic           z_q, z_d, c_q, c_d, n_q, n_d;
   logic [D-1:0]   lut_q [8];
   logic [D-1:0]   lut_d [8];
   logic [D-1:0]   halt_pc_q, halt_pc_d;
   logic [15:0]    taken_cnt_q, taken_cnt_d;
   logic [2:0]     op;
   logic           inv;
   logic [1:0]     cond;
   logic [2:0]     idx;
   logic           sel;
   logic           is_halt;
   logic           is_br;
   logic           taken;
   assign op      = bus.instr[8:6];
   assign inv     = bus.instr[5];
   assign cond    = bus.instr[4:3];
   assign idx     = bus.instr[2:0];
   assign is_halt = bus.instr == 9'h000;
   assign is_br   = op[2:1] == 2'b11;
   assign sel     = cond == 2'b00 ? 1'b1 : cond == 2'b01 ? z_q : cond == 2'b10 ? c_q : n_q;
   assign taken   = state_q == RUN && is_br && (sel ^ inv);
   assign bus.taken_cnt = taken_cnt_q;
   // state transitions and zero-latency jump controls; IDLE/DONE park the PC with an unconditional absolute jump
   always_comb begin
      state_d          = state_q;
      halt_pc_d        = halt_pc_q;
      bus.BranchFlag   = 1'b1;
      bus.BranchInvert = 1'b0;
      bus.reljump      = 1'b0;
      bus.absjump      = 1'b1;
      bus.target       = '0;
      bus.done         = 1'b0;
      if (state_q == RUN) begin
         if (is_halt) begin
            bus.target = bus.prog_ctr;
            halt_pc_d  = bus.prog_ctr;
            state_d    = DONE;
         end else begin
            bus.BranchFlag   = sel;
            bus.BranchInvert = inv;
            bus.reljump      = op == 3'b110;
            bus.absjump      = op == 3'b111;
            bus.target       = is_br ? lut_q[idx] : '0;
         end
      end else if (state_q == DONE) begin
         bus.target = halt_pc_q;
         bus.done   = 1'b1;
         state_d    = bus.start ? IDLE : DONE;
      end else begin
         state_d = bus.start ? RUN : IDLE;
      end
   end
   // flags load only while running, LUT writes are accepted in any state, counter saturates
   always_comb begin
      z_d = (state_q == RUN && bus.flag_we) ? bus.alu_z : z_q;
      c_d = (state_q == RUN && bus.flag_we) ? bus.alu_c : c_q;
      n_d = (state_q == RUN && bus.flag_we) ? bus.alu_n : n_q;
      lut_d = lut_q;
      if (bus.lut_we) lut_d[bus.lut_addr] = bus.lut_data;
      taken_cnt_d = (taken && taken_cnt_q != 16'hFFFF) ? taken_cnt_q + 16'd1 : taken_cnt_q;
   end
   // state register with synchronous reset clearing flags, LUT, halt PC and counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         z_q         <= 1'b0;
         c_q         <= 1'b0;
         n_q         <= 1'b0;
         lut_q       <= '{default: '0};
         halt_pc_q   <= '0;
         taken_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         z_q         <= z_d;
         c_q         <= c_d;
         n_q         <= n_d;
         lut_q       <= lut_d;
         halt_pc_q   <= halt_pc_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: random and directed stimulus checked against a behavioural branch-controller model
module tb_branch_ctrl;
   localparam int D = 12;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   branch_ctrl_if #(.D(D)) bus ();
   branch_ctrl #(.D(D)) dut (.clk(clk), .reset(reset), .bus(bus));
   int total = 0;
   int bad = 0;
   int mode;
   bit mz, mc, mn;
   logic [D-1:0] m_lut [8];
   logic [D-1:0] m_halt;
   int m_cnt;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      mode = 0; mz = 0; mc = 0; mn = 0; m_halt = '0; m_cnt = 0;
      for (int i = 0; i < 8; i++) m_lut[i] = '0;
   endtask
   task automatic quiet();
      bus.start = 0; bus.prog_ctr = '0; bus.instr = 9'h040; bus.alu_z = 0; bus.alu_c = 0; bus.alu_n = 0;
      bus.flag_we = 0; bus.lut_we = 0; bus.lut_addr = 0; bus.lut_data = '0;
   endtask
   task automatic cycle();
      logic [4:0] e;
      logic [D-1:0] et;
      bit tchk, bf, tk;
      int op, cs, ins;
      #1;
      ins = int'(bus.instr);
      op = ins / 64;
      cs = (ins / 8) % 4;
      tchk = 1;
      tk = 0;
      if (mode == 0) begin
         e = 5'b10010; et = '0;
      end else if (mode == 2) begin
         e = 5'b10011; et = m_halt;
      end else if (ins == 0) begin
         e = 5'b10010; et = bus.prog_ctr;
      end else begin
         bf = cs == 0 ? 1'b1 : cs == 1 ? mz : cs == 2 ? mc : mn;
         e = {bf, bus.instr[5], op == 6, op == 7, 1'b0};
         tchk = op >= 6;
         et = m_lut[ins % 8];
         tk = (op >= 6) && (bf != bus.instr[5]);
      end
      chk("jump", {27'd0, bus.BranchFlag, bus.BranchInvert, bus.reljump, bus.absjump, bus.done}, {27'd0, e});
      if (tchk) chk("target", 32'(bus.target), 32'(et));
      chk("cnt", 32'(bus.taken_cnt), m_cnt);
      @(posedge clk);
      if (reset) model_reset();
      else begin
         if (bus.lut_we) m_lut[bus.lut_addr] = bus.lut_data;
         if (mode == 1) begin
            if (bus.flag_we) begin mz = bus.alu_z; mc = bus.alu_c; mn = bus.alu_n; end
            if (ins == 0) begin m_halt = bus.prog_ctr; mode = 2; end
            else if (tk && m_cnt < 65535) m_cnt++;
         end else if (mode == 0) begin
            if (bus.start) mode = 1;
         end else if (bus.start) mode = 0;
      end
      #1;
   endtask
   initial begin
      quiet();
      model_reset();
      reset = 1;
      @(posedge clk); #1;
      cycle();
      reset = 0;
      #1;
      chk("rst_abs", 32'(bus.absjump), 1);
      chk("rst_tgt", 32'(bus.target), 0);
      chk("rst_bf", 32'(bus.BranchFlag), 1);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_cnt", 32'(bus.taken_cnt), 0);
      cycle();
      bus.lut_we = 1; bus.lut_addr = 2; bus.lut_data = 12'hFFC;
      cycle();
      bus.lut_we = 0; bus.start = 1;
      cycle();
      bus.start = 0; bus.instr = 9'b110_0_00_010;
      #1;
      chk("rel_rj", 32'(bus.reljump), 1);
      chk("rel_tgt", 32'(bus.target), 32'h0FFC);
      cycle();
      chk("rel_cnt", 32'(bus.taken_cnt), 1);
      bus.instr = 9'h040; bus.flag_we = 1; bus.alu_z = 1;
      cycle();
      bus.flag_we = 0; bus.alu_z = 0; bus.instr = 9'b111_1_01_000;
      #1;
      chk("inv_aj", 32'(bus.absjump), 1);
      chk("inv_bf", 32'(bus.BranchFlag), 1);
      chk("inv_bi", 32'(bus.BranchInvert), 1);
      cycle();
      chk("inv_cnt", 32'(bus.taken_cnt), 1);
      bus.instr = 9'b110_0_10_000; bus.flag_we = 1; bus.alu_c = 1;
      #1;
      chk("flag_old", 32'(bus.BranchFlag), 0);
      cycle();
      bus.flag_we = 0; bus.alu_c = 0;
      #1;
      chk("flag_new", 32'(bus.BranchFlag), 1);
      cycle();
      bus.instr = 9'h000; bus.prog_ctr = 12'h05A;
      cycle();
      bus.instr = 9'h1FF; bus.prog_ctr = 12'h123;
      #1;
      chk("halt_done", 32'(bus.done), 1);
      chk("halt_tgt", 32'(bus.target), 32'h05A);
      bus.start = 1;
      cycle();
      bus.start = 0;
      #1;
      chk("idle_tgt", 32'(bus.target), 0);
      chk("idle_done", 32'(bus.done), 0);
      bus.start = 1;
      cycle();
      bus.instr = 9'h0C5;
      cycle();
      bus.start = 0;
      cycle();
      repeat (3000) begin
         int r;
         reset = ($urandom_range(0, 199) == 0);
         bus.start = ($urandom_range(0, 3) == 0);
         bus.prog_ctr = D'($urandom());
         r = $urandom_range(0, 15);
         bus.instr = r == 0 ? 9'h000 : r < 11 ? 9'(($urandom_range(6, 7) << 6) | $urandom_range(0, 63)) : 9'($urandom());
         bus.alu_z = 1'($urandom()); bus.alu_c = 1'($urandom()); bus.alu_n = 1'($urandom());
         bus.flag_we = ($urandom_range(0, 2) == 0);
         bus.lut_we = ($urandom_range(0, 3) == 0);
         bus.lut_addr = 3'($urandom()); bus.lut_data = D'($urandom());
         cycle();
      end
      reset = 0;
      quiet();
      reset = 1;
      cycle();
      reset = 0;
      bus.start = 1;
      cycle();
      bus.start = 0;
      bus.instr = 9'b110_0_00_000;
      repeat (65540) @(posedge clk);
      #1;
      m_cnt = 65535;
      chk("sat_cnt", 32'(bus.taken_cnt), 32'hFFFF);
      cycle();
      chk("sat_hold", 32'(bus.taken_cnt), 32'hFFFF);
      bus.lut_we = 1; bus.lut_addr = 3; bus.lut_data = 12'h123;
      cycle();
      bus.lut_we = 0;
      reset = 1;
      cycle();
      reset = 0;
      #1;
      chk("mrst_cnt", 32'(bus.taken_cnt), 0);
      chk("mrst_abs", 32'(bus.absjump), 1);
      chk("mrst_tgt", 32'(bus.target), 0);
      bus.start = 1;
      cycle();
      bus.start = 0;
      for (int i = 0; i < 8; i++) begin
         bus.instr = 9'(9'b111_0_00_000 | i);
         #1;
         chk("lut_clr", 32'(bus.target), 0);
         cycle();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter D, default 12, program-counter and jump-target width.
REQ-002 SHALL have input clk, 1 bit: clock; all state updates on posedge.
REQ-003 SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have input start, 1 bit: single-cycle run request.
REQ-005 SHALL have input prog_ctr, D bits: current program counter value from the PC.
REQ-006 SHALL have input instr, 9 bits: instruction at prog_ctr, combinational from instruction ROM.
REQ-007 SHALL have inputs alu_z, alu_c, alu_n, 1 bit each: ALU zero, carry and negative results of the current instruction.
REQ-008 SHALL have input flag_we, 1 bit: latch the ALU flags at the clock edge.
REQ-009 SHALL have inputs lut_we (1 bit), lut_addr (3 bits) and lut_data (D bits): jump-target table write port.
REQ-010 SHALL have outputs BranchFlag, BranchInvert, reljump and absjump, 1 bit each, and target, D bits; these drive the PC jump controls.
REQ-011 SHALL have output done, 1 bit: program halted.
REQ-012 SHALL have output taken_cnt, 16 bits: count of taken branches.

Function
REQ-013 SHALL decode the instruction fields as follows: op=instr[8:6], inv=instr[5], cond=instr[4:3], idx=instr[2:0].
REQ-014 SHALL define the opcodes as: op 3'b110 = relative branch; op 3'b111 = absolute branch; instr 9'h000 = HALT; everything else is non-branch.
REQ-015 SHALL hold flags Z, C and N in registers, loaded from alu_z, alu_c and alu_n when flag_we=1 and otherwise held.
REQ-016 SHALL evaluate branches against the registered flags only, so a flag write affects the next instruction, never the current one.
REQ-017 SHALL select the condition by cond: 00 = constant 1, 01 = Z, 10 = C, 11 = N; BranchFlag SHALL be the selected value and BranchInvert SHALL be inv.
REQ-018 SHALL keep an 8-entry x D-bit target LUT; a write takes effect at the clock edge, and a same-cycle read of the written index SHALL return the old value.
REQ-019 SHALL drive target = LUT[idx] for branch ops in RUN; relative entries are two's-complement offsets, and the PC wraps modulo 2^D.
REQ-020 SHALL make all jump outputs combinational from instr, the state and the registers, with zero-cycle latency.
REQ-021 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-022 In IDLE, SHALL drive absjump=1, reljump=0, BranchFlag=1, BranchInvert=0, target=0, holding the PC at 0; start SHALL move the FSM to RUN.
REQ-023 In RUN, SHALL drive reljump=1 for op 110, absjump=1 for op 111, and both 0 otherwise; BranchFlag and BranchInvert SHALL follow REQ-017.
REQ-024 In RUN, when instr=9'h000, SHALL latch halt_pc=prog_ctr and move to DONE; that HALT cycle SHALL drive absjump=1, BranchFlag=1, target=prog_ctr.
REQ-025 In DONE, SHALL drive absjump=1, BranchFlag=1, BranchInvert=0, target=halt_pc and done=1; start SHALL move the FSM to IDLE, and start SHALL be ignored in RUN.
REQ-026 SHALL drive done=0 in every state other than DONE.
REQ-027 SHALL increment taken_cnt in RUN at each edge where (reljump|absjump)&(BranchFlag^BranchInvert)=1.
REQ-028 SHALL saturate taken_cnt at 16'hFFFF and exclude HALT cycles and IDLE/DONE hold jumps from the count.
REQ-029 When flag_we and a branch occur in the same cycle, SHALL evaluate the branch on the old flags and load the new flags at the edge.
REQ-030 SHALL hold the flags and the LUT contents in IDLE and DONE, and SHALL accept LUT writes in any state.

Reset
REQ-031 When reset=1 at a clock edge, SHALL set state=IDLE, Z=C=N=0, all LUT entries=0, halt_pc=0 and taken_cnt=0, overriding start, lut_we and flag_we.
REQ-032 A reset in any state, including mid-RUN, SHALL return the block to IDLE, with the outputs per REQ-022 in the following cycle.

Verification
REQ-033 Reset then idle: reset 1 cycle, no start -> absjump=1, target=0, BranchFlag=1, done=0, taken_cnt=0.
REQ-034 Relative taken branch: LUT[2]=12'hFFC, start, instr=9'b110_0_00_010 -> reljump=1, target=12'hFFC, taken_cnt 0->1.
REQ-035 Inverted conditional branch: flag_we with alu_z=1, next cycle instr=9'b111_1_01_000 -> absjump=1, BranchFlag=1, BranchInvert=1, not taken, taken_cnt unchanged.
REQ-036 Flag timing: flag_we with alu_c=1 in the same cycle as instr=9'b110_0_10_000 -> BranchFlag=0 (old C); the same instruction one cycle later -> BranchFlag=1.
REQ-037 Halt and restart: instr=9'h000 at prog_ctr=12'h05A -> next cycle done=1, target=12'h05A; start -> IDLE, target=0; start -> RUN.
REQ-038 Saturation and mid-run reset: force 65536 taken branches -> taken_cnt stays 16'hFFFF; reset mid-RUN -> IDLE, taken_cnt=0, LUT cleared.
